// File: rtl/pc_gen.sv
// Fetch PC generator: trap > redirect > RAS return > sequential, with a circular return-address stack.
// Every pc update lands one cycle after its cause; pc holds while fetch_valid is high and fetch_ready is low.
module pc_gen #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] START_ADDR = 32'h80000000,
    parameter int unsigned      STEP       = 4,
    parameter int unsigned      RAS_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       fetch_valid,
    input  logic                       fetch_ready,
    output logic [WIDTH-1:0]           pc,
    input  logic                       call_push,
    input  logic                       ret_pop,
    input  logic                       redirect_valid,
    input  logic [WIDTH-1:0]           redirect_pc,
    input  logic                       trap_valid,
    input  logic [WIDTH-1:0]           trap_pc,
    output logic [$clog2(RAS_DEPTH):0] ras_count
);
    localparam int unsigned      PW    = $clog2(RAS_DEPTH);
    localparam int unsigned      CW    = PW + 1;
    localparam int unsigned      LSB   = $clog2(STEP);
    localparam logic [WIDTH-1:0] ALIGN = {WIDTH{1'b1}} << LSB;
    localparam logic [CW-1:0]    FULL  = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q;
    logic             valid_q;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    ptr_q;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] ras_top;
    logic [PW-1:0]    ptr_top;
    logic [PW-1:0]    ptr_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [PW-1:0]    ras_waddr;
    logic             ras_we;
    logic             fire;
    logic             do_pop;

    assign pc          = pc_q;
    assign fetch_valid = valid_q;
    assign ras_count   = cnt_q;

    // ptr_q is the next free slot; the newest entry sits one below it.
    assign pc_inc  = pc_q + WIDTH'(STEP);
    assign fire    = valid_q & fetch_ready;
    assign do_pop  = fire & ret_pop & (cnt_q != '0);
    assign ptr_top = ptr_q - PW'(1);
    assign ras_top = ras_q[ptr_top];

    always_comb begin
        pc_nxt    = pc_q;
        cnt_nxt   = cnt_q;
        ptr_nxt   = ptr_q;
        ras_we    = 1'b0;
        ras_waddr = ptr_q;
        if (trap_valid) begin
            pc_nxt  = trap_pc & ALIGN;
            cnt_nxt = '0;
            ptr_nxt = '0;
        end else if (redirect_valid) begin
            pc_nxt = redirect_pc & ALIGN;
        end else if (fire) begin
            pc_nxt = pc_inc;
            if (do_pop) begin
                pc_nxt = ras_top & ALIGN;
                if (call_push) begin
                    // Call and return together: swap the top entry in place.
                    ras_we    = 1'b1;
                    ras_waddr = ptr_top;
                end else begin
                    ptr_nxt = ptr_top;
                    cnt_nxt = cnt_q - CW'(1);
                end
            end else if (call_push) begin
                ras_we    = 1'b1;
                ras_waddr = ptr_q;
                ptr_nxt   = ptr_q + PW'(1);
                if (cnt_q != FULL) begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= START_ADDR;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            pc_q    <= pc_nxt;
            valid_q <= 1'b1;
            cnt_q   <= cnt_nxt;
            ptr_q   <= ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ras_we) begin
            ras_q[ras_waddr] <= pc_inc;
        end
    end
endmodule
